keypad_scanner: RTL and testbench

Drives the 4x4 matrix keypad row lines and samples the column lines to build the raw 16-bit key vector `tempkey` consumed by the keyboard debouncer. One row is strobed at a time with a programmable settle interval, and the assembled frame is published atomically once all four rows are sampled. The block sits between the board keypad pins and the debouncer input, producing the raw, undebounced key image.

---
 rtl/keypad_scanner_pkg.sv | 23 ++
 rtl/keypad_scanner_col_sync.sv | 24 ++
 rtl/keypad_scanner.sv | 64 ++++++
 tb/tb_keypad_scanner.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/keypad_scanner_pkg.sv
// Shared keypad geometry, pin polarities and row-drive helper for the
// keypad scanner slice.
package keypad_scanner_pkg;

  localparam int KEY_ROWS           = 4;
  localparam int KEY_COLS           = 4;
  localparam int KEY_SETTLE_DEFAULT = 50_000;

  // Both row drive and column sense are active-low on the board.
  localparam logic ROW_ACTIVE = 1'b0;
  localparam logic COL_ACTIVE = 1'b0;

  localparam logic [KEY_COLS-1:0] COL_IDLE = {KEY_COLS{~COL_ACTIVE}};

  typedef logic [1:0] row_idx_t;

  function automatic logic [KEY_ROWS-1:0] row_drive(input row_idx_t idx);
    logic [KEY_ROWS-1:0] onehot;
    onehot = KEY_ROWS'(1) << idx;
    return ROW_ACTIVE ? onehot : ~onehot;
  endfunction

endpackage

// File: rtl/keypad_scanner_col_sync.sv
// Two-flop synchronizer for the asynchronous keypad column pins.
// Resets to the idle (no key) pin level.
module col_synchronizer
  import keypad_scanner_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic [KEY_COLS-1:0] col,
  output logic [KEY_COLS-1:0] col_sync
);

  logic [KEY_COLS-1:0] meta;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta     <= COL_IDLE;
      col_sync <= COL_IDLE;
    end else begin
      meta     <= col;
      col_sync <= meta;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad row scanner: strobes one row per settle interval and publishes
// the assembled raw key image once all rows have been sampled.
module keypad_scanner
  import keypad_scanner_pkg::*;
#(
  parameter int SETTLE_CYCLES = KEY_SETTLE_DEFAULT
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         en,
  input  logic [KEY_COLS-1:0]          col,
  output logic [KEY_ROWS-1:0]          row,
  output logic [KEY_ROWS*KEY_COLS-1:0] tempkey,
  output logic                         frame_valid
);

  localparam int                CNT_W    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam row_idx_t          ROW_LAST = row_idx_t'(KEY_ROWS - 1);

  logic [KEY_COLS-1:0]              col_pin_sync;
  logic [KEY_COLS-1:0]              col_s;
  row_idx_t                         row_idx;
  logic [CNT_W-1:0]                 cnt;
  // The last row goes straight into tempkey, so only the earlier rows are buffered.
  logic [(KEY_ROWS-1)*KEY_COLS-1:0] frame;

  col_synchronizer u_col_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .col      (col),
    .col_sync (col_pin_sync)
  );

  assign col_s = COL_ACTIVE ? col_pin_sync : ~col_pin_sync;
  assign row   = row_drive(row_idx);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      row_idx     <= '0;
      cnt         <= '0;
      frame       <= '0;
      tempkey     <= '0;
      frame_valid <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      if (en) begin
        if (cnt < CNT_LAST) begin
          cnt <= cnt + 1'b1;
        end else begin
          cnt     <= '0;
          row_idx <= row_idx + 1'b1;
          if (row_idx == ROW_LAST) begin
            tempkey     <= {col_s, frame};
            frame_valid <= 1'b1;
          end else begin
            frame[row_idx*KEY_COLS +: KEY_COLS] <= col_s;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed and randomized bench for keypad_scanner with a passive keypad model.
module tb_keypad_scanner;

  localparam int SETTLE = 8;
  localparam int FRAME  = 4 * SETTLE;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b1;
  logic [3:0]  col;
  logic [3:0]  row;
  logic [15:0] tempkey;
  logic        frame_valid;

  logic        pressed [4][4];
  int          checks = 0;
  int          errors = 0;

  keypad_scanner #(.SETTLE_CYCLES(SETTLE)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .col         (col),
    .row         (row),
    .tempkey     (tempkey),
    .frame_valid (frame_valid)
  );

  always #5 clk = ~clk;

  // Physical keypad: a pressed key shorts its column to its row while that row is driven low.
  always_comb begin
    col = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r][c] && row[r] == 1'b0) col[c] = 1'b0;
  end

  function automatic logic [15:0] model_image();
    logic [15:0] img;
    img = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r][c]) img[r*4 + c] = 1'b1;
    return img;
  endfunction

  function automatic logic [3:0] model_row(input int t);
    logic [3:0] one;
    one = 4'd1;
    return 4'hF ^ (one << ((t / SETTLE) % 4));
  endfunction

  task automatic clear_keys();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        pressed[r][c] = 1'b0;
  endtask

  task automatic random_keys();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        pressed[r][c] = ($urandom_range(0, 2) == 0);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_pulse(input string tag, input int max, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (frame_valid !== 1'b1 && n < max);
    check({tag, "_pulse"}, {31'd0, frame_valid}, 32'd1);
  endtask

  initial begin
    int n;
    int total;
    logic [15:0] last_img;

    clear_keys();
    rst_n = 1'b0;
    en    = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_row", {28'd0, row}, 32'he);
      check("rst_tempkey", {16'd0, tempkey}, 32'd0);
      check("rst_fv", {31'd0, frame_valid}, 32'd0);
    end
    rst_n = 1'b1;

    for (int t = 1; t <= FRAME; t++) begin
      tick();
      check("scan_row", {28'd0, row}, {28'd0, model_row(t)});
      check("scan_fv", {31'd0, frame_valid}, (t == FRAME) ? 32'd1 : 32'd0);
    end
    check("first_frame", {16'd0, tempkey}, 32'd0);

    pressed[2][1] = 1'b1;
    wait_pulse("single", FRAME + 4, n);
    check("single_period", n, FRAME);
    check("single_key", {16'd0, tempkey}, 32'h0200);

    clear_keys();
    wait_pulse("release", FRAME + 4, n);
    check("release_key", {16'd0, tempkey}, {16'd0, model_image()});

    pressed[0][0] = 1'b1;
    pressed[1][3] = 1'b1;
    pressed[3][3] = 1'b1;
    wait_pulse("multi", FRAME + 4, n);
    check("multi_key", {16'd0, tempkey}, 32'h8081);

    for (int k = 0; k < 6; k++) begin
      random_keys();
      wait_pulse("rand", FRAME + 4, n);
      check("rand_period", n, FRAME);
      check("rand_key", {16'd0, tempkey}, {16'd0, model_image()});
    end

    last_img = model_image();
    random_keys();
    for (int i = 0; i < 12; i++) tick();
    en = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("freeze_row", {28'd0, row}, 32'hd);
      check("freeze_fv", {31'd0, frame_valid}, 32'd0);
      check("freeze_tempkey", {16'd0, tempkey}, {16'd0, last_img});
    end
    en = 1'b1;
    wait_pulse("freeze", FRAME + 4, n);
    total = 12 + 20 + n;
    check("freeze_period", total, FRAME + 20);
    check("freeze_key", {16'd0, tempkey}, {16'd0, model_image()});

    clear_keys();
    pressed[0][0] = 1'b1;
    wait_pulse("pre_rst", FRAME + 4, n);
    check("pre_rst_key", {16'd0, tempkey}, {16'd0, model_image()});
    for (int i = 0; i < 19; i++) tick();
    check("mid_row", {28'd0, row}, 32'hb);
    rst_n = 1'b0;
    tick();
    check("mid_rst_tempkey", {16'd0, tempkey}, 32'd0);
    check("mid_rst_row", {28'd0, row}, 32'he);
    check("mid_rst_fv", {31'd0, frame_valid}, 32'd0);
    rst_n = 1'b1;
    wait_pulse("post_rst", FRAME + 4, n);
    check("post_rst_period", n, FRAME);
    check("post_rst_key", {16'd0, tempkey}, 32'h0001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
